// File: rtl/xintf_pkg.sv
// Shared types and constants for the XINTF bus master.
package xintf_pkg;

  // Bus phase of the master FSM.
  typedef enum logic [1:0] {
    StIdle,
    StLead,
    StActive,
    StTrail
  } xintf_state_e;

  // One shared phase-timing down-counter.
  typedef logic [3:0] tcnt_t;

  // Bus data word.
  typedef logic [15:0] word_t;

  localparam int unsigned LeadDefault   = 2;
  localparam int unsigned ActiveDefault = 4;
  localparam int unsigned TrailDefault  = 2;

  // A phase of N cycles counts N-1 down to 0.
  function automatic tcnt_t phase_load(input int unsigned cycles);
    return tcnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/xintf_sync2.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module xintf_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/xintf_master.sv
// XINTF bus master: one read or write per host command, framed by cs_n with
// LEAD / ACTIVE / TRAIL phases timed by a single shared down-counter.
// Optional build macro XINTF_MASTER_AUTO_READ_EN: a synchronised c_xrd_req
// starts a read on its own while IDLE; a host command takes priority.
module xintf_master
  import xintf_pkg::*;
#(
  parameter int unsigned LEAD   = LeadDefault,
  parameter int unsigned ACTIVE = ActiveDefault,
  parameter int unsigned TRAIL  = TrailDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_wdata,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        cs_n,
  output logic        re_n,
  output logic        we_n,
  output logic        c_xcs_n,
  output logic [15:0] xdata_o,
  output logic        xdata_oe,
  input  logic [15:0] xdata_i,
  input  logic        c_xrd_req,
  output logic        busy
);

  if (LEAD < 1 || LEAD > 15 || ACTIVE < 1 || ACTIVE > 15 || TRAIL < 1 || TRAIL > 15)
  begin : g_param_check
    $error("xintf_master: LEAD, ACTIVE and TRAIL must each be in 1..15");
  end

  localparam tcnt_t LeadLoad   = phase_load(LEAD);
  localparam tcnt_t ActiveLoad = phase_load(ACTIVE);
  localparam tcnt_t TrailLoad  = phase_load(TRAIL);

  xintf_state_e state_q, state_d;
  tcnt_t        cnt_q, cnt_d;
  logic         wr_q, wr_d;
  word_t        wdata_q, wdata_d;
  word_t        rd_data_q, rd_data_d;
  logic         rd_valid_q, rd_valid_d;
  logic         xrd_req_sync;

  xintf_sync2 u_sync_rd_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (c_xrd_req),
    .q_o   (xrd_req_sync)
  );

`ifndef XINTF_MASTER_AUTO_READ_EN
  // Request is synchronised but has no consumer in this build.
  logic unused_xrd_req_sync;
  assign unused_xrd_req_sync = xrd_req_sync;
`endif

  // Next-state: phase sequencing, command capture and read-data capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StLead;
          cnt_d   = LeadLoad;
          wr_d    = cmd_wr;
          wdata_d = cmd_wdata;
        end
`ifdef XINTF_MASTER_AUTO_READ_EN
        else if (xrd_req_sync) begin
          state_d = StLead;
          cnt_d   = LeadLoad;
          wr_d    = 1'b0;
        end
`endif
      end
      StLead: begin
        if (cnt_q == '0) begin
          state_d = StActive;
          cnt_d   = ActiveLoad;
        end else begin
          cnt_d = cnt_q - tcnt_t'(1);
        end
      end
      StActive: begin
        if (cnt_q == '0) begin
          state_d = StTrail;
          cnt_d   = TrailLoad;
          // Sample on the last strobe cycle; report in the first TRAIL cycle.
          if (!wr_q) begin
            rd_data_d  = xdata_i;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - tcnt_t'(1);
        end
      end
      StTrail: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - tcnt_t'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; asynchronous reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Bus outputs decoded from registered state only.
  always_comb begin
    busy      = (state_q != StIdle);
    cmd_ready = ~busy;
    cs_n      = ~busy;
    c_xcs_n   = ~busy;
    re_n      = ~((state_q == StActive) && !wr_q);
    we_n      = ~((state_q == StActive) && wr_q);
    xdata_oe  = busy && wr_q;
    xdata_o   = xdata_oe ? wdata_q : '0;
    rd_valid  = rd_valid_q;
    rd_data   = rd_data_q;
  end

endmodule

// File: doc/xintf_master.md
XINTF_MASTER -- requirements
Module: xintf_master

Interface
REQ-001 Parameter LEAD, default 2: cycles cs_n low before strobe; legal 1..15.
REQ-002 Parameter ACTIVE, default 4: cycles strobe (re_n/we_n) low; legal 1..15.
REQ-003 Parameter TRAIL, default 2: cycles cs_n held low after strobe release; legal 1..15.
REQ-004 clk  in  1  single system clock (50 MHz domain); all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  host command request.
REQ-007 cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&cmd_ready.
REQ-008 cmd_wr  in  1  1=write, 0=read.
REQ-009 cmd_wdata  in  16  write data.
REQ-010 rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-011 rd_data  out  16  captured read word.
REQ-012 cs_n, re_n, we_n  out  1 each  XINTF strobes, active-low.
REQ-013 c_xcs_n  out  1  custom select; low for whole transaction (LEAD+ACTIVE+TRAIL).
REQ-014 xdata_o  out  16 / xdata_oe  out  1 / xdata_i  in  16  split tristate; top-level drives inout.
REQ-015 c_xrd_req  in  1  slave frame-ready request, asynchronous to clk.
REQ-016 busy  out  1  high when not IDLE.

Function
REQ-017 FSM states IDLE, LEAD, ACTIVE, TRAIL; one shared down-counter, 4 bits.
REQ-018 IDLE->LEAD on accept; counter loaded LEAD-1; cs_n=c_xcs_n=0 from first LEAD cycle.
REQ-019 LEAD->ACTIVE at counter 0; re_n (read) or we_n (write) low for exactly ACTIVE cycles.
REQ-020 ACTIVE->TRAIL at counter 0; strobe high, cs_n low for exactly TRAIL cycles; TRAIL->IDLE at 0.
REQ-021 Read: xdata_i sampled on last ACTIVE cycle; rd_valid pulses in first TRAIL cycle.
REQ-022 Write: cmd_wdata latched at accept; xdata_oe=1 from first LEAD to last TRAIL cycle; xdata_oe=0 throughout reads.
REQ-023 re_n and we_n never both low; strobes never low while cs_n high.
REQ-024 Transaction length exactly LEAD+ACTIVE+TRAIL cycles; back-to-back: next accept in IDLE cycle after TRAIL, at least one cycle with cs_n high between transactions.
REQ-025 cmd_valid outside IDLE ignored (cmd_ready=0); no queuing.
REQ-026 c_xrd_req passed through 2-FF synchroniser before use.

Reset
REQ-027 On rst_n low: state IDLE, cs_n=re_n=we_n=c_xcs_n=1, xdata_oe=0, xdata_o=0, rd_valid=0, rd_data=0, busy=0, synchroniser=0.
REQ-028 Reset mid-transaction aborts immediately; no rd_valid emitted; bus released in same cycle as assertion.

Configuration
REQ-029 Macro XINTF_MASTER_AUTO_READ_EN defined: in IDLE with synchronised c_xrd_req=1 and cmd_valid=0, FSM starts read itself; rd_valid reported identically; host cmd_valid wins on simultaneous request.
REQ-030 Macro undefined: c_xrd_req only synchronised and ignored; transactions start from cmd only.

Structure
REQ-031 Shared package xintf_pkg: state enum, 4-bit timing counter type, default LEAD/ACTIVE/TRAIL constants, 16-bit word type.
REQ-032 One sub-module xintf_sync2 (2-FF synchroniser, reset to 0); FSM and datapath in xintf_master.

Verification
REQ-033 Defaults, read cmd, slave drives 16'h5F5F -> cs_n low 8 cycles, re_n low 4 cycles, rd_valid one pulse, rd_data=16'h5F5F, we_n stays 1.
REQ-034 Write cmd_wdata=16'hA55A -> xdata_oe=1 and xdata_o=16'hA55A for 8 cycles, we_n low cycles 3..6, re_n stays 1.
REQ-035 cmd_valid held high 3 reads -> 3 rd_valid pulses, cs_n high exactly 1 cycle between transactions.
REQ-036 rst_n low during ACTIVE of read -> all strobes 1, xdata_oe 0 same cycle, no rd_valid, cmd_ready 1 after release.
REQ-037 AUTO_READ_EN defined, c_xrd_req=1 -> read starts 3 cycles later (sync + accept); with cmd_valid also high, write executes first.
REQ-038 LEAD=1, ACTIVE=1, TRAIL=1 -> transaction 3 cycles, strobes never overlap, protocol assertions REQ-023 pass.
